// File: rtl/alu_pkg.sv
// alu_pkg: shared width and RV32I funct3 operation codes for the ALU slice
package alu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'd0,
    F3_SLL     = 3'd1,
    F3_SLT     = 3'd2,
    F3_SLTU    = 3'd3,
    F3_XOR     = 3'd4,
    F3_SRL_SRA = 3'd5,
    F3_OR      = 3'd6,
    F3_AND     = 3'd7
  } funct3_e;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/control bundle and results between a decoder and the ALU
interface alu_if;
  import alu_pkg::*;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [2:0]      funct3;
  logic            funct7_4;
  logic            alu_en;
  logic            alu_imm;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] alu_out_q;
  modport master (output in_a, in_b, funct3, funct7_4, alu_en, alu_imm, input alu_out, alu_out_q);
  modport slave (input in_a, in_b, funct3, funct7_4, alu_en, alu_imm, output alu_out, alu_out_q);
endinterface

// File: rtl/alu_shifter.sv
// alu_shifter: 32-bit barrel shifter for SLL, SRL and SRA
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [4:0]      shamt,
  input  logic            dir,
  input  logic            arith,
  output logic [XLEN-1:0] result
);
  logic [XLEN:0]   ext;
  logic [XLEN-1:0] sr;
  // one extra sign bit lets a single arithmetic shift serve both SRL and SRA
  assign ext    = {arith & data[XLEN-1], data};
  assign sr     = XLEN'($signed(ext) >>> shamt);
  assign result = dir ? sr : data << shamt;
endmodule

// File: rtl/alu.sv
// alu: RV32I integer ALU with combinational and registered result
module alu
  import alu_pkg::*;
(
  input logic   clk,
  input logic   rst,
  alu_if.slave  bus
);
  funct3_e         op;
  logic            sub;
  logic            inv;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] sh;
  logic            lt;
  logic            ltu;
  assign op  = funct3_e'(bus.funct3);
  assign sub = op == F3_ADD_SUB && bus.funct7_4 && !bus.alu_imm;
  // compares reuse the subtractor: a - b carry-out and sign give the order
  assign inv = bus.alu_en && (sub || op == F3_SLT || op == F3_SLTU);
  assign sum = {1'b0, bus.in_a} + {1'b0, bus.in_b ^ {XLEN{inv}}} + (XLEN+1)'(inv);
  assign ltu = !sum[XLEN];
  assign lt  = (bus.in_a[XLEN-1] != bus.in_b[XLEN-1]) ? bus.in_a[XLEN-1] : sum[XLEN-1];
  alu_shifter u_shifter (
    .data   (bus.in_a),
    .shamt  (bus.in_b[4:0]),
    .dir    (op == F3_SRL_SRA),
    .arith  (bus.funct7_4),
    .result (sh)
  );
  assign bus.alu_out = !bus.alu_en                    ? sum[XLEN-1:0] :
                       op == F3_ADD_SUB               ? sum[XLEN-1:0] :
                       op == F3_SLL || op == F3_SRL_SRA ? sh :
                       op == F3_SLT                   ? XLEN'(lt) :
                       op == F3_SLTU                  ? XLEN'(ltu) :
                       op == F3_XOR                   ? bus.in_a ^ bus.in_b :
                       op == F3_OR                    ? bus.in_a | bus.in_b :
                                                        bus.in_a & bus.in_b;
  always_ff @(posedge clk)
    bus.alu_out_q <= rst ? '0 : bus.alu_out;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu, combinational and registered result
module tb_alu;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  alu_if bus ();
  alu dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                                        input logic f7, input logic en, input logic imm);
    if (!en) return a + b;
    case (f3)
      3'd0: return (f7 && !imm) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, $signed(a) < $signed(b)};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic f7, input logic en, input logic imm, input logic r, input logic [31:0] exp);
    @(negedge clk);
    bus.in_a = a;
    bus.in_b = b;
    bus.funct3 = f3;
    bus.funct7_4 = f7;
    bus.alu_en = en;
    bus.alu_imm = imm;
    rst = r;
    #1;
    check(tag, bus.alu_out, exp);
    sb.push_back(r ? 32'h0 : exp);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) check("alu_out_q", bus.alu_out_q, sb.pop_front());
  end

  initial begin
    drive("rst", 32'h1, 32'h1, 3'd0, 0, 1, 0, 1, 32'h2);
    drive("add1", 32'h1, 32'h1, 3'd0, 0, 1, 0, 0, 32'h2);
    drive("add_rst", 32'h1, 32'h1, 3'd0, 0, 1, 0, 1, 32'h2);
    drive("add_reload", 32'h1, 32'h1, 3'd0, 0, 1, 0, 0, 32'h2);
    drive("add2", 32'hffff8000, 32'h80000000, 3'd0, 0, 1, 0, 0, 32'h7fff8000);
    drive("add3", 32'hffffffff, 32'h00000001, 3'd0, 0, 1, 0, 0, 32'h0);
    drive("add4", 32'h00000001, 32'h7fffffff, 3'd0, 0, 1, 0, 0, 32'h80000000);
    drive("sub1", 32'h3, 32'h7, 3'd0, 1, 1, 0, 0, 32'hfffffffc);
    drive("sub2", 32'h0, 32'hffffffff, 3'd0, 1, 1, 0, 0, 32'h1);
    drive("subi1", 32'h3, 32'h7, 3'd0, 1, 1, 1, 0, 32'ha);
    drive("subi2", 32'h0, 32'hffffffff, 3'd0, 1, 1, 1, 0, 32'hffffffff);
    drive("sll14", 32'h21212121, 32'd14, 3'd1, 0, 1, 0, 0, 32'h48484000);
    drive("sll31", 32'h21212121, 32'd31, 3'd1, 0, 1, 0, 0, 32'h80000000);
    drive("sll0hi", 32'h21212121, 32'hffffffe0, 3'd1, 0, 1, 1, 0, 32'h21212121);
    drive("srl14", 32'h80000001, 32'd14, 3'd5, 0, 1, 0, 0, 32'h00020000);
    drive("srl31", 32'h80000001, 32'd31, 3'd5, 0, 1, 1, 0, 32'h1);
    drive("sra1", 32'h80000001, 32'd1, 3'd5, 1, 1, 0, 0, 32'hc0000000);
    drive("sra30", 32'h80000001, 32'd30, 3'd5, 1, 1, 1, 0, 32'hfffffffe);
    drive("sra30p", 32'h40000001, 32'd30, 3'd5, 1, 1, 0, 0, 32'h1);
    drive("sra31", 32'h80000000, 32'd31, 3'd5, 1, 1, 0, 0, 32'hffffffff);
    drive("sra0", 32'h80000001, 32'd0, 3'd5, 1, 1, 0, 0, 32'h80000001);
    drive("slt1", 32'h80000001, 32'h1, 3'd2, 0, 1, 0, 0, 32'h1);
    drive("slt2", 32'hffffffff, 32'h7fffffff, 3'd2, 0, 1, 0, 0, 32'h1);
    drive("slt3", 32'h7, 32'h3, 3'd2, 0, 1, 0, 0, 32'h0);
    drive("slt_eq", 32'h80000000, 32'h80000000, 3'd2, 0, 1, 0, 0, 32'h0);
    drive("sltu1", 32'h80000000, 32'h1, 3'd3, 0, 1, 0, 0, 32'h0);
    drive("sltu2", 32'h1, 32'h3, 3'd3, 0, 1, 0, 0, 32'h1);
    drive("sltu_eq", 32'hffffffff, 32'hffffffff, 3'd3, 0, 1, 0, 0, 32'h0);
    drive("xor", 32'hff00ff00, 32'hf00ff00f, 3'd4, 0, 1, 0, 0, 32'h0f0f0f0f);
    drive("or", 32'hff00ff00, 32'h0f0f0f0f, 3'd6, 0, 1, 0, 0, 32'hff0fff0f);
    drive("and", 32'hf00ff00f, 32'hf0f0f0f0, 3'd7, 0, 1, 0, 0, 32'hf000f000);
    drive("fadd", 32'h3, 32'h7, 3'd7, 1, 0, 0, 0, 32'ha);
    drive("fadd_slt", 32'h3, 32'h7, 3'd2, 1, 0, 1, 0, 32'ha);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      logic [2:0] f3;
      logic f7, en, imm, r;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 7 == 0) b = a;
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom);
      en = ($urandom_range(0, 7) != 0);
      imm = 1'($urandom);
      r = ($urandom_range(0, 15) == 0);
      drive("rand", a, b, f3, f7, en, imm, r, model(a, b, f3, f7, en, imm));
    end
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits.
REQ-002 SHALL have port: clk  input  1  single clock; rising-edge active.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: in_a  input  32  operand A (rs1 value).
REQ-005 SHALL have port: in_b  input  32  operand B (rs2 value or immediate).
REQ-006 SHALL have port: funct3  input  3  RV32I operation select.
REQ-007 SHALL have port: funct7_4  input  1  instruction bit 30; selects SUB / SRA.
REQ-008 SHALL have port: alu_en  input  1  1 = decode funct3; 0 = forced ADD (address/PC arithmetic).
REQ-009 SHALL have port: alu_imm  input  1  1 = I-type operation (in_b is immediate).
REQ-010 SHALL have port: alu_out  output  32  combinational result.
REQ-011 SHALL have port: alu_out_q  output  32  result registered on clk.

Function
REQ-012 alu_out SHALL be purely combinational from in_a, in_b, funct3, funct7_4, alu_en, alu_imm; zero-cycle latency; no dependence on clk/rst.
REQ-013 alu_en=0 SHALL give alu_out = in_a + in_b (mod 2^32), regardless of funct3, funct7_4, alu_imm.
REQ-014 alu_en=1, funct3=000: SUB (in_a - in_b, mod 2^32) when funct7_4=1 and alu_imm=0; otherwise ADD; no overflow flag, carry discarded.
REQ-015 funct3=001 (SLL): in_a << in_b[4:0]; in_b[31:5] ignored; zeros fill.
REQ-016 funct3=010 (SLT): 32'd1 if signed(in_a) < signed(in_b), else 32'd0.
REQ-017 funct3=011 (SLTU): 32'd1 if unsigned(in_a) < unsigned(in_b), else 32'd0.
REQ-018 funct3=100 (XOR): in_a ^ in_b.
REQ-019 funct3=101: funct7_4=0 -> SRL (zero fill); funct7_4=1 -> SRA (replicate in_a[31]); shift by in_b[4:0]; funct7_4 honoured for both alu_imm values.
REQ-020 funct3=110 (OR): in_a | in_b; funct3=111 (AND): in_a & in_b.
REQ-021 Shift by 0 SHALL return in_a unchanged; shift by 31 SHALL be supported for all shift types.
REQ-022 Equal operands SHALL give SLT/SLTU = 0; output SHALL never be X for known inputs.
REQ-023 alu_out_q SHALL load alu_out on every rising clk edge when rst=0 (one-cycle latency, no enable).

Reset
REQ-024 When rst=1 at a rising clk edge, alu_out_q SHALL become 32'h0; rst takes priority over load.
REQ-025 rst SHALL NOT affect alu_out; reset mid-operation only clears alu_out_q, next non-reset edge reloads it.

Structure
REQ-026 Shared package alu_pkg SHALL hold funct3 constants (ADD_SUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL_SRA=5, OR=6, AND=7) and width constant XLEN=32.
REQ-027 One sub-module alu_shifter (32-bit barrel shifter: data, shamt[4:0], direction, arithmetic) SHALL implement SLL/SRL/SRA.
REQ-028 Adder/subtractor SHALL share one 32-bit adder (in_b inverted, carry-in 1 for SUB); SLT/SLTU may reuse it.

Verification
REQ-029 ADD: alu_en=1, funct3=0, funct7_4=0: ffff8000+80000000 -> 7fff8000; ffffffff+00000001 -> 00000000; 00000001+7fffffff -> 80000000.
REQ-030 SUB: funct7_4=1, alu_imm=0: 3-7 -> fffffffc; 0-ffffffff -> 00000001; same inputs with alu_imm=1 -> ADD results.
REQ-031 Shifts: SLL 21212121 by 14 -> 48484000, by 31 -> 80000000; SRL 80000001 by 14 -> 00020000; SRA 80000001 by 1 -> c0000000, by 30 -> fffffffe; SRA 40000001 by 30 -> 00000001.
REQ-032 Compare: SLT 80000001,00000001 -> 1; SLT ffffffff,7fffffff -> 1; SLTU 80000000,00000001 -> 0; SLTU 1,3 -> 1; SLT 7,3 -> 0.
REQ-033 Logic/forced add: XOR ff00ff00^f00ff00f -> 0f0f0f0f; OR ff00ff00|0f0f0f0f -> ff0fff0f; AND f00ff00f&f0f0f0f0 -> f000f000; alu_en=0, funct3=7, funct7_4=1, 3+7 -> 0000000a.
REQ-034 Register: rst=1 one edge -> alu_out_q=0; rst=0, ADD 1+1 -> alu_out_q=2 after next edge; rst asserted with operands present -> alu_out_q=0 while alu_out=2.
